fsm_seq_monitor: RTL and testbench

Parametrised, multi-channel successor to the single-channel 4-state Mealy sequence FSM. Runs CH independent copies of the fixed S0–S3 transition table sharing one free-running window counter that freezes all state updates once it reaches WIN, and keeps a per-channel up/down balance counter of the Mealy output. Sits between the input sampling stage and the output/observation logic as a clock-enabled sequence monitor.

---
 rtl/fsm_seq_monitor.sv | 100 ++++++++++
 tb/tb_fsm_seq_monitor.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/fsm_seq_monitor.sv
// Multi-channel Mealy sequence monitor: CH copies of the S0-S3 table gated by a shared window counter.
// Optional build macro FSM_BAL_SAT_EN makes the per-channel balance counters saturate instead of wrap.
module fsm_seq_monitor #(
    parameter int CH  = 2,
    parameter int CW  = 4,
    parameter int WIN = 10,
    parameter int BW  = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic [CH-1:0]      in,
    output logic [CH-1:0]      out,
    output logic [2*CH-1:0]    state_o,
    output logic [CH*BW-1:0]   bal_o,
    output logic [CW-1:0]      cnt_o,
    output logic               frozen
);

    typedef enum logic [1:0] {
        S0 = 2'b00,
        S1 = 2'b01,
        S2 = 2'b10,
        S3 = 2'b11
    } state_e;

    state_e          state_q   [CH];
    state_e          state_d   [CH];
    state_e          nxt_state [CH];
    logic [BW-1:0]   bal_q     [CH];
    logic [BW-1:0]   bal_d     [CH];
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   cnt_d;

    // NOTE: every register, including the small per-channel arrays, is reset so the outputs are defined at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            for (int c = 0; c < CH; c++) begin
                state_q[c] <= S0;
                bal_q[c]   <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments keep every register sampling the pre-edge values.
            cnt_q <= cnt_d;
            for (int c = 0; c < CH; c++) begin
                state_q[c] <= state_d[c];
                bal_q[c]   <= bal_d[c];
            end
        end
    end

    always_comb begin
        // NOTE: defaults first so no path through the case leaves a signal unassigned (no latches).
        frozen = (cnt_q >= CW'(WIN));
        cnt_d  = en ? cnt_q + CW'(1) : cnt_q;
        out    = '1;
        for (int c = 0; c < CH; c++) begin
            nxt_state[c] = state_q[c];
            state_d[c]   = state_q[c];
            bal_d[c]     = bal_q[c];

            unique case (state_q[c])
                S0: begin nxt_state[c] = in[c] ? S3 : S1; out[c] = 1'b1;  end
                S1: begin nxt_state[c] = in[c] ? S2 : S0; out[c] = 1'b1;  end
                S2: begin nxt_state[c] = in[c] ? S0 : S3; out[c] = in[c]; end
                S3: begin nxt_state[c] = in[c] ? S1 : S3; out[c] = 1'b0;  end
                default: begin nxt_state[c] = S0; out[c] = 1'b1; end
            endcase

            if (en) begin
                if (!frozen) begin
                    state_d[c] = nxt_state[c];
                end
`ifdef FSM_BAL_SAT_EN
                if (out[c]) begin
                    bal_d[c] = (bal_q[c] == '1) ? bal_q[c] : bal_q[c] + BW'(1);
                end else begin
                    bal_d[c] = (bal_q[c] == '0) ? bal_q[c] : bal_q[c] - BW'(1);
                end
`else
                // Balance tracks the Mealy output even while the window is frozen.
                bal_d[c] = out[c] ? bal_q[c] + BW'(1) : bal_q[c] - BW'(1);
`endif
            end
        end
    end

    always_comb begin
        state_o = '0;
        bal_o   = '0;
        for (int c = 0; c < CH; c++) begin
            state_o[2*c +: 2] = state_q[c];
            bal_o[BW*c +: BW] = bal_q[c];
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: tb/tb_fsm_seq_monitor.sv
// Randomized and directed checks of fsm_seq_monitor against a table-driven reference model.
module tb_fsm_seq_monitor;

    localparam int CH  = 2;
    localparam int CW  = 4;
    localparam int WIN = 10;
    localparam int BW  = 4;
    localparam int CMOD = 1 << CW;
    localparam int BMOD = 1 << BW;

    logic               clk = 1'b0;
    logic               reset;
    logic               en;
    logic [CH-1:0]      in;
    logic [CH-1:0]      out;
    logic [2*CH-1:0]    state_o;
    logic [CH*BW-1:0]   bal_o;
    logic [CW-1:0]      cnt_o;
    logic               frozen;

    fsm_seq_monitor #(.CH(CH), .CW(CW), .WIN(WIN), .BW(BW)) dut (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .in      (in),
        .out     (out),
        .state_o (state_o),
        .bal_o   (bal_o),
        .cnt_o   (cnt_o),
        .frozen  (frozen)
    );

    always #5 clk = ~clk;

    // Transition table indexed [state][in], states numbered 0..3.
    int nxt_tab [4][2] = '{'{1, 3}, '{0, 2}, '{3, 0}, '{3, 1}};
    int out_tab [4][2] = '{'{1, 1}, '{1, 1}, '{0, 1}, '{0, 0}};

    int m_state [CH];
    int m_bal   [CH];
    int m_cnt;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef FSM_BAL_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_cnt = 0;
        for (int c = 0; c < CH; c++) begin
            m_state[c] = 0;
            m_bal[c]   = 0;
        end
    endtask

    function automatic logic [CH-1:0] m_out(input logic [CH-1:0] i);
        logic [CH-1:0] o;
        for (int c = 0; c < CH; c++) o[c] = out_tab[m_state[c]][i[c]] != 0;
        return o;
    endfunction

    task automatic m_step(input logic e, input logic [CH-1:0] i);
        logic [CH-1:0] o;
        if (!e) return;
        o = m_out(i);
        for (int c = 0; c < CH; c++) begin
            if (m_cnt < WIN) m_state[c] = nxt_tab[m_state[c]][i[c]];
            if (SAT) begin
                if (o[c]) m_bal[c] = (m_bal[c] == BMOD - 1) ? m_bal[c] : m_bal[c] + 1;
                else      m_bal[c] = (m_bal[c] == 0) ? 0 : m_bal[c] - 1;
            end else begin
                m_bal[c] = (m_bal[c] + (o[c] ? 1 : BMOD - 1)) % BMOD;
            end
        end
        m_cnt = (m_cnt + 1) % CMOD;
    endtask

    task automatic compare_regs();
        logic [2*CH-1:0]  es;
        logic [CH*BW-1:0] eb;
        for (int c = 0; c < CH; c++) begin
            es[2*c +: 2]  = 2'(m_state[c]);
            eb[BW*c +: BW] = BW'(m_bal[c]);
        end
        check("state_o", 64'(state_o), 64'(es));
        check("bal_o",   64'(bal_o),   64'(eb));
        check("cnt_o",   64'(cnt_o),   64'(m_cnt));
        check("frozen",  64'(frozen),  64'(m_cnt >= WIN));
    endtask

    // Called at a falling edge: drive, check the combinational output, take one rising edge, check registers.
    task automatic step(input logic e, input logic [CH-1:0] i);
        en = e;
        in = i;
        #1;
        check("out", 64'(out), 64'(m_out(i)));
        @(posedge clk);
        m_step(e, i);
        @(negedge clk);
        compare_regs();
    endtask

    // Asynchronous reset pulse entirely between two rising edges.
    task automatic pulse_reset();
        en = 1'b0;
        #2 reset = 1'b1;
        #1;
        m_reset();
        check("rst_state", 64'(state_o), 64'(0));
        check("rst_cnt",   64'(cnt_o),   64'(0));
        check("rst_bal",   64'(bal_o),   64'(0));
        check("rst_frz",   64'(frozen),  64'(0));
        check("rst_out",   64'(out),     64'({CH{1'b1}}));
        #1 reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        en    = 1'b0;
        in    = '0;
        m_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        compare_regs();

        // Channel 0 held at 0: ten toggles, freeze, wrap after sixteen edges.
        for (int k = 0; k < 10; k++) step(1'b1, 2'b00);
        check("win_state0", 64'(state_o[1:0]), 64'(0));
        check("win_cnt",    64'(cnt_o),        64'(10));
        check("win_frozen", 64'(frozen),       64'(1));
        for (int k = 0; k < 6; k++) step(1'b1, 2'b00);
        check("wrap_cnt",  64'(cnt_o),      64'(0));
        check("wrap_bal0", 64'(bal_o[3:0]), SAT ? 64'(15) : 64'(0));
        step(1'b1, 2'b00);
        check("resume_s1", 64'(state_o[1:0]), 64'(1));

        // Channel 1 held at 1: S3,S1,S2,S0 with balance 2 after four edges.
        pulse_reset();
        for (int k = 0; k < 4; k++) step(1'b1, 2'b10);
        check("ch1_bal4", 64'(bal_o[7:4]), 64'(2));
        for (int k = 0; k < 4; k++) step(1'b1, 2'b10);
        check("ch1_bal8", 64'(bal_o[7:4]), 64'(4));

        // One high bit into S3, then stuck there driving the balance downward.
        pulse_reset();
        step(1'b1, 2'b01);
        check("s3_enter", 64'(state_o[1:0]), 64'(3));
        step(1'b1, 2'b00);
        check("s3_bal0", 64'(bal_o[3:0]), 64'(0));
        step(1'b1, 2'b00);
        check("s3_under", 64'(bal_o[3:0]), SAT ? 64'(0) : 64'(15));

        // Enable low for five cycles at cnt 4 while inputs toggle.
        pulse_reset();
        for (int k = 0; k < 4; k++) step(1'b1, 2'(k));
        for (int k = 0; k < 5; k++) step(1'b0, 2'($urandom_range(0, 3)));
        check("hold_cnt", 64'(cnt_o), 64'(4));

        // Reach frozen region, then reset asynchronously.
        for (int k = 0; k < 8; k++) step(1'b1, 2'b11);
        check("frz_cnt12", 64'(cnt_o), 64'(12));
        pulse_reset();
        step(1'b1, 2'b01);
        check("post_rst", 64'(state_o), 64'(4'b0111));

        // Independent channels with in=01 across a full window period.
        pulse_reset();
        for (int k = 0; k < 20; k++) step(1'b1, 2'b01);

        // Random traffic with occasional enable drops and resets.
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 99) == 0) pulse_reset();
            step($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
